// File: rtl/seq_mult_32_if.sv
// rtl/seq_mult_32_if.sv - handshake/operand/result bundle for the sequential multiplier
interface seq_mult_32_if;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/seq_mult_32.sv
// rtl/seq_mult_32.sv - 32-cycle shift-add MULT/MULTU unit producing a registered HI/LO pair
module seq_mult_32 #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  seq_mult_32_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             load;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    // Magnitudes are taken as unsigned, so |0x80000000| stays 0x80000000.
    a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
    load  = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

    sum      = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod     = {p_hi_q, p_lo_q};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;

    case (state_q)
      S_CALC: begin
        {p_hi_d, p_lo_d} = {sum, p_lo_q[WIDTH-1:1]};
        cnt_d            = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        {p_hi_d, p_lo_d} = prod_fix;
        {hi_d, lo_d}     = prod_fix;
        state_d          = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      mcand_d = a_mag;
      p_hi_d  = '0;
      p_lo_d  = b_mag;
      cnt_d   = '0;
      neg_d   = bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      state_d = S_CALC;
    end

    busy_d = (state_d == S_CALC) || (state_d == S_SIGN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_seq_mult_32.sv
// tb/tb_seq_mult_32.sv - randomized and directed checks of seq_mult_32 against a cycle-count product model
module tb_seq_mult_32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_mult_32_if bus ();

  seq_mult_32 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit run_chk  = 1'b0;

  // Reference: the product from plain integer arithmetic.
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    logic [63:0] ux, uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  // Model: k counts cycles since the accepted start (0 = idle, 34 = done cycle).
  int          k = 0;
  logic [63:0] pending = '0;
  logic [63:0] exp_prod = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k        = 0;
      exp_prod = '0;
    end else if (k == 0 || k == 34) begin
      if (bus.start) begin
        pending = ref_prod(bus.a, bus.b, bus.is_signed);
        k       = 1;
      end else begin
        k = 0;
      end
    end else begin
      k = k + 1;
      if (k == 34) exp_prod = pending;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("cycle_outputs",
          {30'd0, bus.busy, bus.done},
          {30'd0, (k >= 1 && k <= 33), (k == 34)});
      chk("cycle_hilo", {bus.hi, bus.lo}, exp_prod);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int t0;

  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic s);
    bus.start     = 1'b1;
    bus.a         = x;
    bus.b         = y;
    bus.is_signed = s;
    step();
    t0            = cyc;
    bus.start     = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string name, input logic [63:0] exp);
    int n = 0;
    while (!bus.done && n < 100) begin
      step();
      n++;
    end
    chk({name, "_latency"}, 64'(cyc - t0 + 1), 64'd34);
    chk({name, "_prod"}, {bus.hi, bus.lo}, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;

    chk("pin_mult_neg", ref_prod(32'hFFFFFFFD, 32'h5, 1'b1), 64'hFFFFFFFF_FFFFFFF1);
    chk("pin_multu", ref_prod(32'hFFFFFFFD, 32'h5, 1'b0), 64'h00000004_FFFFFFF1);
    chk("pin_min_min", ref_prod(32'h80000000, 32'h80000000, 1'b1), 64'h40000000_00000000);

    step();
    step();
    chk("reset_state", {30'd0, bus.busy, bus.done, bus.hi, bus.lo}, 96'd0);
    rst = 1'b0;
    run_chk = 1'b1;
    step();

    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done("multu_max", 64'hFFFFFFFE_00000001);
    step();
    launch(32'hFFFFFFFD, 32'h00000005, 1'b1);
    wait_done("mult_neg3x5", 64'hFFFFFFFF_FFFFFFF1);
    step();
    launch(32'hFFFFFFFD, 32'h00000005, 1'b0);
    wait_done("multu_3x5", 64'h00000004_FFFFFFF1);
    step();
    launch(32'h80000000, 32'h80000000, 1'b1);
    wait_done("mult_minxmin", 64'h40000000_00000000);
    step();
    launch(32'h80000000, 32'h00000001, 1'b1);
    wait_done("mult_minx1", 64'hFFFFFFFF_80000000);
    step();
    launch(32'h0, 32'h12345678, 1'b1);
    wait_done("zero_op", 64'h0);
    step();

    // Second start mid-operation must be ignored.
    launch(32'h00010000, 32'h00010000, 1'b0);
    repeat (9) step();
    bus.start = 1'b1;
    bus.a     = 32'h2;
    bus.b     = 32'h2;
    step();
    bus.start = 1'b0;
    wait_done("ignored_start", 64'h00000001_00000000);
    step();

    // Start held high through busy and into DONE: next op captured at DONE.
    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    bus.start     = 1'b1;
    bus.a         = 32'd7;
    bus.b         = 32'd6;
    bus.is_signed = 1'b0;
    wait_done("b2b_first", 64'hFFFFFFFE_00000001);
    step();
    t0        = cyc;
    bus.start = 1'b0;
    wait_done("b2b_second", 64'h00000000_0000002A);
    step();

    // Reset in the middle of an operation.
    launch(32'h00001234, 32'h00005678, 1'b0);
    repeat (19) step();
    rst = 1'b1;
    #1;
    chk("rst_async", {30'd0, bus.busy, bus.done, bus.hi, bus.lo}, 96'd0);
    repeat (3) step();
    rst = 1'b0;
    repeat (40) step();
    chk("rst_no_done", {63'd0, bus.done}, 64'd0);
    launch(32'hFFFFFFF9, 32'h00000003, 1'b1);
    wait_done("after_rst", 64'hFFFFFFFF_FFFFFFEB);
    step();

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i == 0) ra = 32'h80000000;
      if (i == 1) rb = 32'h0;
      launch(ra, rb, rs);
      wait_done("random", ref_prod(ra, rb, rs));
      if ($urandom_range(0, 1) == 1) step();
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mult_32.md
Name: seq_mult_32

Overview:
- Multi-cycle shift-add multiplier for MULT/MULTU in the execute stage.
- Sits downstream of the ID stage and wraps a 32-bit carry-lookahead add path. Each iteration it feeds the partial-product high word and the multiplicand into the adder and consumes the 32-bit sum plus carry-out.
- Produces the 64-bit product into HI/LO.
- Holds a busy flag so the pipeline stalls hazard-dependent MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width. The only supported value is 32; the iteration counter is 6 bits wide.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a multiply; sampled on the rising edge.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU. Sampled with start.
- a  input  32  multiplicand. Sampled with start.
- b  input  32  multiplier. Sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; hi/lo are valid from this cycle on.
- hi  output  32  product bits [63:32], registered.
- lo  output  32  product bits [31:0], registered.

Behaviour:
Reset:
- rst=1 forces state IDLE, busy=0, done=0, hi=0, lo=0, and clears the counter and all internal registers immediately (asynchronously).
- A reset during CALC or SIGN aborts the operation. No done pulse is issued.

States:
- IDLE
  - start=1 captures the operands and goes to CALC.
  - If is_signed=1, the stored operands are |a| and |b|, and neg = a[31]^b[31]. Otherwise the raw operands are stored and neg=0.
  - |0x80000000| = 0x80000000 (unsigned magnitude; no overflow).
  - The accumulator P_hi is cleared to 0, P_lo is loaded with the multiplier, and the counter is cleared to 0.
- CALC (exactly 32 cycles)
  - When P_lo[0]=1: {c,sum} = P_hi + mcand through the 33-bit result (32-bit sum plus carry-out). Otherwise {c,sum} = {0,P_hi}.
  - Then {P_hi,P_lo} <= {c,sum,P_lo[31:1]}, i.e. a 65-bit logical right shift by 1.
  - The counter increments every cycle. When the counter equals 31, the next state is SIGN.
- SIGN (1 cycle)
  - If neg=1, {P_hi,P_lo} <= 64-bit two's complement of itself. Otherwise it is held.
  - Next state is DONE.
- DONE (1 cycle)
  - hi/lo outputs are loaded from {P_hi,P_lo}, visible in this cycle, and done=1.
  - With start=1 in this cycle, a new operation is captured (same as IDLE) and the next state is CALC. Otherwise the next state is IDLE.

Outputs:
- busy=1 in CALC and SIGN; busy=0 in IDLE and DONE.
- done=1 only in DONE.
- hi/lo hold their last product until the next DONE. They are never changed by start alone.

Timing and hazards:
- Latency: start sampled at edge 0, CALC occupies cycles 1..32, SIGN is cycle 33, and done is high in cycle 34. Back-to-back throughput is one result per 34 cycles.
- start while busy=1 is ignored, and the operands are not resampled.
- a, b and is_signed changing after the start edge have no effect on the operation in flight.
- Zero operands still take the full 34 cycles (no early exit).

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done in cycle 34, hi=0xFFFFFFFE, lo=0x00000001; busy high for cycles 1..33.
- MULT a=0xFFFFFFFD (-3), b=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. The same operands as MULTU -> hi=0x00000004, lo=0xFFFFFFF1.
- MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000. MULT a=0x80000000, b=0x00000001 -> hi=0xFFFFFFFF, lo=0x80000000.
- start pulsed again at cycle 10 with a=b=0x00000002 during an op of 0x00010000*0x00010000 -> ignored; result hi=0x00000001, lo=0x00000000.
- Back-to-back: start held high through DONE with new operands 7*6 -> second done 34 cycles later, lo=0x0000002A, hi=0. The first result stays on hi/lo until then.
- rst asserted in cycle 20 of an operation -> immediate busy=0, hi=lo=0, no done pulse. A fresh start after release gives a correct product.
